mf_trigger: RTL and testbench

MF_TRIGGER -- requirements
Module: mf_trigger

---
 rtl/mf_trigger.sv | 162 ++++++++++++++++
 tb/tb_mf_trigger.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mf_trigger.sv
// Matched-filter threshold trigger: three-stage pipeline (|x|, compare/max, priority + FSM)
// with holdoff, held trigger index/peak and a saturating trigger counter.
module mf_trigger #(
  parameter int unsigned NBITS   = 18,
  parameter int unsigned NSAMPS  = 8,
  parameter int unsigned HOLDOFF = 16,
  parameter int unsigned CNTBITS = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NBITS*NSAMPS-1:0]   data_i,
  input  logic [NBITS-2:0]          thresh_i,
  input  logic                      enable_i,
  input  logic                      cnt_clr_i,
  output logic                      trig_o,
  output logic [2:0]                trig_idx_o,
  output logic [NBITS-2:0]          peak_o,
  output logic [CNTBITS-1:0]        trig_cnt_o,
  output logic                      armed_o
);

  localparam int unsigned MW = NBITS - 1;
  localparam int unsigned HW = 16;
  localparam logic [NBITS-1:0]   MOST_NEG  = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [MW-1:0]      MAG_MAX   = '1;
  localparam logic [HW-1:0]      HOLD_LOAD = HW'(HOLDOFF - 1);
  localparam logic [CNTBITS-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HOLD} state_t;

  logic [NBITS-1:0]   w_samp [NSAMPS];
  logic [MW-1:0]      w_mag  [NSAMPS];
  logic [MW-1:0]      r_mag  [NSAMPS];
  logic [MW-1:0]      r_thr;
  logic [NSAMPS-1:0]  w_flag;
  logic [MW-1:0]      w_max;
  logic [NSAMPS-1:0]  r_flag;
  logic [MW-1:0]      r_max;
  logic [2:0]         w_idx;
  logic               w_any;
  logic               w_fire;

  state_t             r_state;
  logic [HW-1:0]      r_hold;
  logic               r_trig;
  logic [2:0]         r_idx;
  logic [MW-1:0]      r_peak;
  logic [CNTBITS-1:0] r_cnt;
  logic               r_armed;

  // Saturating magnitude: the most negative code has no positive twin.
  always_comb begin
    for (int i = 0; i < NSAMPS; i++) begin
      w_samp[i] = data_i[NBITS*i +: NBITS];
      if (w_samp[i] == MOST_NEG)
        w_mag[i] = MAG_MAX;
      else if (w_samp[i][NBITS-1])
        w_mag[i] = MW'(~w_samp[i] + NBITS'(1));
      else
        w_mag[i] = MW'(w_samp[i]);
    end
  end

  always_comb begin
    w_flag = '0;
    w_max  = '0;
    for (int i = 0; i < NSAMPS; i++) begin
      w_flag[i] = r_mag[i] > r_thr;
      if (r_mag[i] > w_max) w_max = r_mag[i];
    end
  end

  // Lowest flagged index wins.
  always_comb begin
    w_idx = '0;
    for (int i = NSAMPS - 1; i >= 0; i--) begin
      if (r_flag[i]) w_idx = 3'(i);
    end
  end

  assign w_any  = |r_flag;
  assign w_fire = enable_i && (r_state == S_ARMED) && w_any;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NSAMPS; i++) r_mag[i] <= '0;
      r_thr  <= '0;
      r_flag <= '0;
      r_max  <= '0;
    end else begin
      for (int i = 0; i < NSAMPS; i++) r_mag[i] <= w_mag[i];
      r_thr  <= thresh_i;
      r_flag <= w_flag;
      r_max  <= w_max;
    end
  end

  // Trigger FSM; holdoff returns to ARMED on the edge the counter reaches zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_trig  <= 1'b0;
      r_idx   <= '0;
      r_peak  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_trig <= 1'b0;
      if (!enable_i) begin
        r_state <= S_IDLE;
        r_hold  <= '0;
        r_armed <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_ARMED;
            r_armed <= 1'b1;
          end
          S_ARMED: begin
            if (w_any) begin
              r_state <= S_HOLD;
              r_armed <= 1'b0;
              r_trig  <= 1'b1;
              r_idx   <= w_idx;
              r_peak  <= r_max;
              r_hold  <= HOLD_LOAD;
            end
          end
          S_HOLD: begin
            if (r_hold <= HW'(1)) begin
              r_state <= S_ARMED;
              r_armed <= 1'b1;
              r_hold  <= '0;
            end else begin
              r_hold <= r_hold - HW'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      r_cnt <= '0;
    else if (cnt_clr_i)
      r_cnt <= w_fire ? CNTBITS'(1) : '0;
    else if (w_fire && (r_cnt != CNT_MAX))
      r_cnt <= r_cnt + CNTBITS'(1);
  end

  assign trig_o     = r_trig;
  assign trig_idx_o = r_idx;
  assign peak_o     = r_peak;
  assign trig_cnt_o = r_cnt;
  assign armed_o    = r_armed;

endmodule

// File: tb/tb_mf_trigger.sv
// Bench for mf_trigger: directed scenarios plus randomized traffic against a
// behavioural model (block evaluation + next-allowed-trigger edge bookkeeping).
module tb_mf_trigger;

  localparam int unsigned NBITS   = 18;
  localparam int unsigned NSAMPS  = 8;
  localparam int unsigned HOLDOFF = 16;
  localparam int unsigned CNTBITS = 4;
  localparam int unsigned MW      = NBITS - 1;
  localparam int          MAXM    = (1 << (NBITS - 1)) - 1;
  localparam int          CMAX    = (1 << CNTBITS) - 1;

  logic                     aclk = 1'b0;
  logic                     aresetn;
  logic [NBITS*NSAMPS-1:0]  data_i;
  logic [MW-1:0]            thresh_i;
  logic                     enable_i;
  logic                     cnt_clr_i;
  logic                     trig_o;
  logic [2:0]               trig_idx_o;
  logic [MW-1:0]            peak_o;
  logic [CNTBITS-1:0]       trig_cnt_o;
  logic                     armed_o;

  mf_trigger #(.NBITS(NBITS), .NSAMPS(NSAMPS), .HOLDOFF(HOLDOFF), .CNTBITS(CNTBITS)) dut (
    .aclk(aclk), .aresetn(aresetn), .data_i(data_i), .thresh_i(thresh_i),
    .enable_i(enable_i), .cnt_clr_i(cnt_clr_i), .trig_o(trig_o),
    .trig_idx_o(trig_idx_o), .peak_o(peak_o), .trig_cnt_o(trig_cnt_o), .armed_o(armed_o)
  );

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_fail = 0;
  int e      = 0;

  // Reference model state
  logic [NBITS*NSAMPS-1:0] s1_d, s2_d;
  logic [MW-1:0]           s1_t, s2_t;
  bit  m_active, m_trig, m_armed;
  int  m_ready, m_idx, m_peak, m_cnt;

  function automatic int samp(input logic [NBITS*NSAMPS-1:0] d, input int i);
    logic signed [NBITS-1:0] v;
    v = d[NBITS*i +: NBITS];
    return int'(v);
  endfunction

  function automatic int absmag(input int x);
    int m;
    m = (x < 0) ? -x : x;
    return (m > MAXM) ? MAXM : m;
  endfunction

  task automatic model_reset();
    s1_d = '0; s2_d = '0; s1_t = '0; s2_t = '0;
    m_active = 0; m_trig = 0; m_armed = 0;
    m_ready = 0; m_idx = 0; m_peak = 0; m_cnt = 0;
  endtask

  // A block reaches the decision two edges after capture; a trigger blocks
  // further triggers until HOLDOFF edges later.
  task automatic model_edge();
    int m, idx, pk;
    bit any, fire;
    any = 0; idx = 0; pk = 0; fire = 0;
    for (int i = 0; i < NSAMPS; i++) begin
      m = absmag(samp(s2_d, i));
      if (m > int'(s2_t) && !any) begin any = 1; idx = i; end
      if (m > pk) pk = m;
    end
    if (!enable_i) m_active = 0;
    else if (!m_active) begin m_active = 1; m_ready = e + 1; end
    else if (any && e >= m_ready) begin
      fire = 1; m_ready = e + HOLDOFF; m_idx = idx; m_peak = pk;
    end
    m_trig  = fire;
    m_armed = m_active && (m_ready <= e + 1);
    if (cnt_clr_i) m_cnt = fire ? 1 : 0;
    else if (fire && m_cnt < CMAX) m_cnt++;
    s2_d = s1_d; s2_t = s1_t;
    s1_d = data_i; s1_t = thresh_i;
  endtask

  task automatic tick();
    @(posedge aclk);
    e++;
    if (aresetn) model_edge();
    #1;
  endtask

  task automatic put(input int i, input int v);
    data_i[NBITS*i +: NBITS] = NBITS'(v);
  endtask

  task automatic quiet();
    data_i = '0;
    repeat (HOLDOFF + 2) tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b0; enable_i = 0; cnt_clr_i = 0; data_i = '0; thresh_i = '0;
    model_reset();
    #1;
    n_chk += 5;
    if (trig_o !== 1'b0)      begin n_fail++; $display("FAIL reset_trig got=%0b exp=0", trig_o); end
    if (trig_idx_o !== 3'd0)  begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", trig_idx_o); end
    if (peak_o !== '0)        begin n_fail++; $display("FAIL reset_peak got=%0d exp=0", peak_o); end
    if (trig_cnt_o !== '0)    begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", trig_cnt_o); end
    if (armed_o !== 1'b0)     begin n_fail++; $display("FAIL reset_armed got=%0b exp=0", armed_o); end
    repeat (2) tick();
    aresetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (armed_o !== 1'b0 || trig_o !== 1'b0) begin
        n_fail++; $display("FAIL idle_after_reset edge=%0d got=%0b/%0b exp=0/0", e, armed_o, trig_o);
      end
    end
    enable_i = 1;
    tick();
    n_chk++;
    if (armed_o !== 1'b1) begin n_fail++; $display("FAIL first_arm got=%0b exp=1", armed_o); end
  endtask

  task automatic test_single();
    thresh_i = MW'(1000);
    data_i = '0; put(5, -1500);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) data_i = '0;
      n_chk++;
      if (trig_o !== (c == 3)) begin n_fail++; $display("FAIL single_trig c=%0d got=%0b exp=%0b", c, trig_o, c == 3); end
      if (c == 3) begin
        n_chk += 3;
        if (trig_idx_o !== 3'd5)    begin n_fail++; $display("FAIL single_idx got=%0d exp=5", trig_idx_o); end
        if (peak_o !== MW'(1500))   begin n_fail++; $display("FAIL single_peak got=%0d exp=1500", peak_o); end
        if (trig_cnt_o !== 4'd1)    begin n_fail++; $display("FAIL single_cnt got=%0d exp=1", trig_cnt_o); end
      end
    end
    n_chk++;
    if (trig_idx_o !== 3'd5) begin n_fail++; $display("FAIL single_idx_hold got=%0d exp=5", trig_idx_o); end
  endtask

  task automatic test_priority();
    quiet();
    put(2, 1001); put(6, 4000);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) data_i = '0;
    end
    n_chk += 3;
    if (trig_o !== 1'b1)       begin n_fail++; $display("FAIL prio_trig got=%0b exp=1", trig_o); end
    if (trig_idx_o !== 3'd2)   begin n_fail++; $display("FAIL prio_idx got=%0d exp=2", trig_idx_o); end
    if (peak_o !== MW'(4000))  begin n_fail++; $display("FAIL prio_peak got=%0d exp=4000", peak_o); end
    quiet();
    put(3, 1000); put(7, -1000);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) data_i = '0;
      n_chk++;
      if (trig_o !== 1'b0) begin n_fail++; $display("FAIL equal_thresh c=%0d got=%0b exp=0", c, trig_o); end
    end
  endtask

  task automatic test_saturate();
    quiet();
    thresh_i = MW'(131070);
    put(0, -131072);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) data_i = '0;
    end
    n_chk += 3;
    if (trig_o !== 1'b1)         begin n_fail++; $display("FAIL sat_trig got=%0b exp=1", trig_o); end
    if (peak_o !== MW'(131071))  begin n_fail++; $display("FAIL sat_peak got=%0d exp=131071", peak_o); end
    if (trig_idx_o !== 3'd0)     begin n_fail++; $display("FAIL sat_idx got=%0d exp=0", trig_idx_o); end
    thresh_i = MW'(1000);
  endtask

  task automatic test_continuous();
    int t[$];
    int c0;
    quiet();
    c0 = e;
    for (int i = 0; i < NSAMPS; i++) put(i, 2000);
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (c == 40) data_i = '0;
      n_chk++;
      if (trig_o !== m_trig) begin n_fail++; $display("FAIL cont_trig edge=%0d got=%0b exp=%0b", e, trig_o, m_trig); end
      if (trig_o === 1'b1) t.push_back(e - c0);
    end
    n_chk++;
    if (t.size() != 3) begin n_fail++; $display("FAIL cont_count got=%0d exp=3", t.size()); end
    else begin
      n_chk += 3;
      if (t[0] != 3)                begin n_fail++; $display("FAIL cont_first got=%0d exp=3", t[0]); end
      if (t[1] - t[0] != 16)        begin n_fail++; $display("FAIL cont_gap1 got=%0d exp=16", t[1] - t[0]); end
      if (t[2] - t[0] != 32)        begin n_fail++; $display("FAIL cont_gap2 got=%0d exp=32", t[2] - t[0]); end
    end
  endtask

  task automatic test_enable_drop();
    quiet();
    put(1, 5000);
    tick(); data_i = '0;
    tick();
    enable_i = 0;
    tick();
    n_chk += 2;
    if (trig_o !== 1'b0)  begin n_fail++; $display("FAIL endrop_trig got=%0b exp=0", trig_o); end
    if (armed_o !== 1'b0) begin n_fail++; $display("FAIL endrop_idle got=%0b exp=0", armed_o); end
    enable_i = 1;
    tick();
    n_chk++;
    if (armed_o !== 1'b1) begin n_fail++; $display("FAIL endrop_rearm got=%0b exp=1", armed_o); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      data_i = '0;
      for (int i = 0; i < NSAMPS; i++) begin
        if ($urandom_range(0, 99) < 6) put(i, int'($urandom_range(0, 6000)) - 3000);
        else if ($urandom_range(0, 99) < 2) put(i, -131072);
        else put(i, int'($urandom_range(0, 1600)) - 800);
      end
      if ($urandom_range(0, 49) == 0) thresh_i = MW'($urandom_range(500, 2500));
      enable_i  = ($urandom_range(0, 99) >= 4);
      cnt_clr_i = ($urandom_range(0, 99) < 3);
      tick();
      n_chk += 5;
      if (trig_o !== m_trig)               begin n_fail++; $display("FAIL rnd_trig edge=%0d got=%0b exp=%0b", e, trig_o, m_trig); end
      if (armed_o !== m_armed)             begin n_fail++; $display("FAIL rnd_armed edge=%0d got=%0b exp=%0b", e, armed_o, m_armed); end
      if (trig_cnt_o !== CNTBITS'(m_cnt))  begin n_fail++; $display("FAIL rnd_cnt edge=%0d got=%0d exp=%0d", e, trig_cnt_o, m_cnt); end
      if (trig_idx_o !== 3'(m_idx))        begin n_fail++; $display("FAIL rnd_idx edge=%0d got=%0d exp=%0d", e, trig_idx_o, m_idx); end
      if (peak_o !== MW'(m_peak))          begin n_fail++; $display("FAIL rnd_peak edge=%0d got=%0d exp=%0d", e, peak_o, m_peak); end
    end
    enable_i = 1; cnt_clr_i = 0; thresh_i = MW'(1000);
  endtask

  task automatic test_reset_count();
    int n;
    int want;
    quiet();
    put(4, 3000);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) data_i = '0;
    end
    aresetn = 1'b0;
    model_reset();
    #1;
    n_chk += 5;
    if (trig_o !== 1'b0)      begin n_fail++; $display("FAIL rst_hold_trig got=%0b exp=0", trig_o); end
    if (trig_idx_o !== 3'd0)  begin n_fail++; $display("FAIL rst_hold_idx got=%0d exp=0", trig_idx_o); end
    if (peak_o !== '0)        begin n_fail++; $display("FAIL rst_hold_peak got=%0d exp=0", peak_o); end
    if (trig_cnt_o !== '0)    begin n_fail++; $display("FAIL rst_hold_cnt got=%0d exp=0", trig_cnt_o); end
    if (armed_o !== 1'b0)     begin n_fail++; $display("FAIL rst_hold_armed got=%0b exp=0", armed_o); end
    repeat (2) tick();
    aresetn = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      n_chk++;
      if (trig_o !== 1'b0) begin n_fail++; $display("FAIL rst_no_trig edge=%0d got=%0b exp=0", e, trig_o); end
    end
    n = 0;
    for (int i = 0; i < NSAMPS; i++) put(i, 2000);
    for (int c = 0; c < 400 && n < 20; c++) begin
      cnt_clr_i = (n == 17) && (m_ready == e + 1);
      tick();
      if (trig_o === 1'b1) begin
        n++;
        want = (n <= 15) ? n : (n < 18) ? 15 : n - 17;
        n_chk++;
        if (trig_cnt_o !== CNTBITS'(want)) begin
          n_fail++; $display("FAIL cnt_trig%0d got=%0d exp=%0d", n, trig_cnt_o, want);
        end
      end
    end
    cnt_clr_i = 0;
    data_i = '0;
    n_chk += 2;
    if (n != 20)               begin n_fail++; $display("FAIL cnt_ntrig got=%0d exp=20", n); end
    if (trig_cnt_o !== 4'd3)   begin n_fail++; $display("FAIL cnt_final got=%0d exp=3", trig_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_saturate();
    test_continuous();
    test_enable_drop();
    test_random();
    test_reset_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
